load_store_unit: RTL

//   Memory stage directly downstream of the ALU. It takes the ALU ADD result as the effective

---
 rtl/load_store_unit_pkg.sv | 42 ++++
 rtl/load_store_unit_if.sv | 22 ++
 rtl/load_store_unit_align.sv | 52 +++++
 rtl/load_store_unit.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: funct3 access codes, fault causes,
// FSM states and the op-classification helper used at accept time.
package load_store_unit_pkg;

  localparam int LSU_XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_ILLEGAL  = 2'b10,
    CAUSE_TIMEOUT  = 2'b11
  } fault_cause_e;

  // Illegal encodings take priority; alignment is only judged for legal ops.
  function automatic fault_cause_e classify(input logic       is_load,
                                            input logic       is_store,
                                            input logic [2:0] funct3,
                                            input logic [1:0] lo);
    logic illegal;
    logic misaligned;
    illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
              (is_store && funct3[2]) || (is_load == is_store);
    misaligned = ((funct3[1:0] == 2'b01) && lo[0]) ||
                 ((funct3[1:0] == 2'b10) && (lo != 2'b00));
    if (illegal)         return CAUSE_ILLEGAL;
    else if (misaligned) return CAUSE_MISALIGN;
    else                 return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory req/ack bus between the LSU (master) and the memory (slave).
interface load_store_unit_if #(
  parameter int XLEN = 32
) ();
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_wstrb;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: store byte/half replication with byte strobes,
// and load byte/half/word extraction with sign or zero extension.
module load_store_unit_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  st_funct3_i,
  input  logic [1:0]  st_lo_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] st_wdata_o,
  output logic [3:0]  st_wstrb_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_lo_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_value_o
);

  logic [31:0] shifted;

  // Store steering: replicate the datum across all lanes and enable only the addressed ones.
  always_comb begin
    st_wdata_o = st_data_i;
    st_wstrb_o = 4'b1111;
    case (st_funct3_i[1:0])
      2'b00: begin
        st_wdata_o = {4{st_data_i[7:0]}};
        st_wstrb_o = 4'b0001 << st_lo_i;
      end
      2'b01: begin
        st_wdata_o = {2{st_data_i[15:0]}};
        st_wstrb_o = 4'b0011 << st_lo_i;
      end
      default: begin
        st_wdata_o = st_data_i;
        st_wstrb_o = 4'b1111;
      end
    endcase
  end

  // Load extraction: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    shifted    = ld_rdata_i >> {ld_lo_i, 3'b000};
    ld_value_o = shifted;
    case (ld_funct3_i)
      F3_B:    ld_value_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   ld_value_o = {24'b0, shifted[7:0]};
      F3_H:    ld_value_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   ld_value_o = {16'b0, shifted[15:0]};
      default: ld_value_o = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: accepts one load/store from EX, runs a single req/ack bus
// transaction (or faults without one), and retires it with a one-cycle
// done/writeback/fault pulse. FSM: IDLE -> REQ -> RESP -> IDLE.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int XLEN        = LSU_XLEN,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_flush,
  input  logic             i_is_load,
  input  logic             i_is_store,
  input  logic [2:0]       i_funct3,
  input  logic [XLEN-1:0]  i_addr,
  input  logic [XLEN-1:0]  i_store_data,
  input  logic [4:0]       i_rd,
  load_store_unit_if.master mem,
  output logic             o_wb_valid,
  output logic [4:0]       o_wb_rd,
  output logic [XLEN-1:0]  o_wb_data,
  output logic             o_done,
  output logic             o_fault,
  output logic [1:0]       o_fault_cause
);

  localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

  lsu_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic         killed_q, killed_d;
  fault_cause_e cause_q, cause_d;

  logic            is_load_q;
  logic [2:0]      funct3_q;
  logic [1:0]      lo_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [3:0]      wstrb_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] ldata_q;

  logic            accept;
  logic            ack_hit;
  logic            at_limit;
  fault_cause_e    new_cause;
  logic [XLEN-1:0] st_wdata;
  logic [3:0]      st_wstrb;
  logic [XLEN-1:0] ld_value;
  logic            in_req;
  logic            in_resp;
  logic            fault_vis;

  assign accept    = i_valid && (state_q == ST_IDLE) && !i_flush;
  assign ack_hit   = (state_q == ST_REQ) && mem.mem_ack;
  assign at_limit  = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));
  assign new_cause = classify(i_is_load, i_is_store, i_funct3, i_addr[1:0]);

  load_store_unit_align u_align (
    .st_funct3_i (i_funct3),
    .st_lo_i     (i_addr[1:0]),
    .st_data_i   (i_store_data),
    .st_wdata_o  (st_wdata),
    .st_wstrb_o  (st_wstrb),
    .ld_funct3_i (funct3_q),
    .ld_lo_i     (lo_q),
    .ld_rdata_i  (mem.mem_rdata),
    .ld_value_o  (ld_value)
  );

  // Control state: FSM, timeout counter, kill flag and fault cause.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      killed_q <= 1'b0;
      cause_q  <= CAUSE_NONE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      killed_q <= killed_d;
      cause_q  <= cause_d;
    end
  end

  // Next-state logic; faulting ops skip REQ, an ack on the limit cycle beats the timeout.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    killed_d = killed_q;
    cause_d  = cause_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d    = '0;
          killed_d = 1'b0;
          cause_d  = new_cause;
          state_d  = (new_cause == CAUSE_NONE) ? ST_REQ : ST_RESP;
        end
      end
      ST_REQ: begin
        killed_d = killed_q || i_flush;
        if (mem.mem_ack) begin
          state_d = ST_RESP;
        end else if (at_limit) begin
          state_d = ST_RESP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture at accept and load-data capture at the ack edge (datapath, no reset).
  always_ff @(posedge i_clk) begin
    if (accept) begin
      is_load_q <= i_is_load;
      funct3_q  <= i_funct3;
      lo_q      <= i_addr[1:0];
      addr_q    <= {i_addr[XLEN-1:2], 2'b00};
      wdata_q   <= st_wdata;
      wstrb_q   <= st_wstrb;
      rd_q      <= i_rd;
      ldata_q   <= '0;
    end else if (ack_hit && is_load_q) begin
      ldata_q   <= ld_value;
    end
  end

  assign in_req    = (state_q == ST_REQ);
  assign in_resp   = (state_q == ST_RESP);
  assign fault_vis = in_resp && (cause_q != CAUSE_NONE) && !killed_q;

  assign o_ready       = (state_q == ST_IDLE);
  assign mem.mem_req   = in_req;
  assign mem.mem_we    = in_req && !is_load_q;
  assign mem.mem_addr  = in_req ? addr_q : '0;
  assign mem.mem_wdata = (in_req && !is_load_q) ? wdata_q : '0;
  assign mem.mem_wstrb = (in_req && !is_load_q) ? wstrb_q : 4'b0000;

  assign o_done        = in_resp;
  assign o_fault       = fault_vis;
  assign o_fault_cause = fault_vis ? cause_q : CAUSE_NONE;
  assign o_wb_valid    = in_resp && is_load_q && (rd_q != 5'd0) && !killed_q &&
                         (cause_q == CAUSE_NONE);
  assign o_wb_rd       = o_wb_valid ? rd_q : 5'd0;
  assign o_wb_data     = (in_resp && is_load_q && (cause_q == CAUSE_NONE)) ? ldata_q : '0;

endmodule
